// File: rtl/perf_event_monitor.sv
// ============================================================================
// perf_event_monitor: gated event/cycle counters with snapshot shadow bank
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_event_monitor #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               clear,
  input  logic               snap,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               running,
  output logic               done
);

  localparam int                NUM_CNT = NUM_EVT + 1;
  localparam logic [SEL_W-1:0]  CYC_SEL = SEL_W'(NUM_EVT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q    [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d    [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d [NUM_CNT];
  logic [NUM_EVT:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_EVT:0]   inc;
  logic               load_shadow;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN:    if (halt)  state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Top bit is the cycle tick; counters saturate and flag instead of wrapping.
  always_comb begin
    inc   = {1'b1, evt};
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (state_q == ST_RUN && inc[k]) begin
        if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
        else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      if (clear) cnt_d[k] = '0;
    end
    if (clear) ovf_d = '0;
  end

  // Halting auto-snapshots the post-increment values, same as an explicit snap.
  always_comb begin
    load_shadow = snap || (state_q == ST_RUN && halt);
    for (int k = 0; k < NUM_CNT; k++) begin
      shadow_d[k] = shadow_q[k];
      if (load_shadow) shadow_d[k] = cnt_d[k];
      if (clear)       shadow_d[k] = '0;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_sel <= CYC_SEL) rd_data_d = shadow_d[rd_sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k]    <= cnt_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
// ============================================================================
// tb_perf_event_monitor: directed vector table plus corner-case sequences
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_event_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-width instance
  logic        start, halt, clear, snap;
  logic [4:0]  evt;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [5:0]  ovf;
  logic        running, done;

  // Narrow instance for saturation
  logic        s_start, s_halt, s_clear, s_snap;
  logic [4:0]  s_evt;
  logic [2:0]  s_rd_sel;
  logic [3:0]  s_rd_data;
  logic [5:0]  s_ovf;
  logic        s_running, s_done;

  perf_event_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .snap(snap), .evt(evt), .rd_sel(rd_sel), .rd_data(rd_data),
    .ovf(ovf), .running(running), .done(done)
  );

  perf_event_monitor #(.NUM_EVT(5), .CNT_W(4), .SEL_W(3)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .halt(s_halt), .clear(s_clear),
    .snap(s_snap), .evt(s_evt), .rd_sel(s_rd_sel), .rd_data(s_rd_data),
    .ovf(s_ovf), .running(s_running), .done(s_done)
  );

  typedef struct {
    logic        start, halt, clear, snap;
    logic [4:0]  evt;
    logic [2:0]  sel;
    logic [31:0] exp_rd;
    logic        exp_run, exp_done;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic st, ha, cl, sn, input logic [4:0] e,
                              input logic [2:0] s, input logic [31:0] rd,
                              input logic r, d);
    vec_t v;
    v.start = st; v.halt = ha; v.clear = cl; v.snap = sn;
    v.evt = e; v.sel = s; v.exp_rd = rd; v.exp_run = r; v.exp_done = d;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    {start, halt, clear, snap, evt, rd_sel} = '0;
    {s_start, s_halt, s_clear, s_snap, s_evt, s_rd_sel} = '0;

    //       st ha cl sn evt       sel rd  run done
    add(1, 0, 0, 0, 5'b00000, 0, 0,  1, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 5'b00001, 0, 0, 1, 0);
    add(0, 0, 0, 1, 5'b00000, 0, 10, 1, 0);
    add(0, 0, 0, 0, 5'b00000, 5, 11, 1, 0);
    add(0, 0, 0, 0, 5'b00000, 7, 0,  1, 0);
    add(0, 0, 0, 0, 5'b00000, 0, 10, 1, 0);
    add(0, 0, 0, 0, 5'b00110, 1, 0,  1, 0);
    add(0, 0, 0, 1, 5'b01010, 3, 1,  1, 0);
    add(0, 0, 0, 0, 5'b00000, 1, 2,  1, 0);
    add(0, 0, 0, 0, 5'b00000, 2, 1,  1, 0);
    add(1, 0, 0, 0, 5'b00000, 5, 16, 1, 0);
    add(0, 1, 0, 0, 5'b10000, 4, 1,  0, 1);
    add(0, 0, 0, 0, 5'b11111, 5, 20, 0, 1);
    add(1, 0, 0, 0, 5'b11111, 0, 10, 0, 1);
    add(0, 0, 0, 1, 5'b11111, 4, 1,  0, 1);
    add(0, 0, 0, 1, 5'b00000, 5, 20, 0, 1);
    add(0, 0, 1, 0, 5'b00000, 5, 0,  0, 0);
    add(1, 0, 0, 0, 5'b00000, 5, 0,  1, 0);
    add(0, 0, 0, 0, 5'b00001, 0, 0,  1, 0);
    add(1, 1, 1, 1, 5'b11111, 0, 0,  0, 0);
    add(0, 0, 0, 1, 5'b00000, 0, 0,  0, 0);
    add(0, 0, 0, 1, 5'b00000, 5, 0,  0, 0);

    repeat (2) tick();
    check("reset rd_data", rd_data, 0);
    check("reset ovf", 32'(ovf), 0);
    check("reset running", 32'(running), 0);
    check("reset done", 32'(done), 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].start; halt = tbl[i].halt; clear = tbl[i].clear;
      snap = tbl[i].snap; evt = tbl[i].evt; rd_sel = tbl[i].sel;
      tick();
      check($sformatf("v%0d rd_data", i), rd_data, tbl[i].exp_rd);
      check($sformatf("v%0d running", i), 32'(running), 32'(tbl[i].exp_run));
      check($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].exp_done));
      check($sformatf("v%0d ovf", i), 32'(ovf), 0);
    end
    {start, halt, clear, snap, evt, rd_sel} = '0;

    // Saturation on the 4-bit instance
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_evt = 5'b00100;
    repeat (15) tick();
    check("sat ovf before wrap", 32'(s_ovf), 0);
    tick();
    check("sat ovf at wrap", 32'(s_ovf), 32'h24);
    repeat (4) tick();
    s_evt = '0; s_snap = 1'b1; s_rd_sel = 3'd2;
    tick(); s_snap = 1'b0;
    check("sat cnt2 held", 32'(s_rd_data), 15);
    s_rd_sel = 3'd5;
    tick();
    check("sat cycle held", 32'(s_rd_data), 15);
    check("sat ovf sticky", 32'(s_ovf), 32'h24);
    s_clear = 1'b1; tick(); s_clear = 1'b0;
    check("sat clear ovf", 32'(s_ovf), 0);
    check("sat clear running", 32'(s_running), 0);
    check("sat clear rd", 32'(s_rd_data), 0);
    s_evt = 5'b00100; repeat (2) tick();
    s_evt = '0; s_snap = 1'b1; s_rd_sel = 3'd2;
    tick(); s_snap = 1'b0;
    check("sat idle no count", 32'(s_rd_data), 0);

    // Asynchronous reset in the middle of a run
    start = 1'b1; s_start = 1'b1; tick();
    start = 1'b0; s_start = 1'b0;
    evt = 5'b00001; s_evt = 5'b00100;
    repeat (17) tick();
    evt = '0; s_evt = '0; snap = 1'b1; rd_sel = 3'd0;
    tick(); snap = 1'b0;
    check("pre-rst rd_data", rd_data, 17);
    check("pre-rst running", 32'(running), 1);
    check("pre-rst sat ovf", 32'(s_ovf), 32'h24);
    #3 rst = 1'b0;
    #1;
    check("async rst rd_data", rd_data, 0);
    check("async rst ovf", 32'(ovf), 0);
    check("async rst running", 32'(running), 0);
    check("async rst done", 32'(done), 0);
    check("async rst sat ovf", 32'(s_ovf), 0);
    check("async rst sat running", 32'(s_running), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    evt = 5'b00001;
    repeat (3) tick();
    check("post-rst stays idle", 32'(running), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("post-rst start", 32'(running), 1);
    repeat (2) tick();
    evt = '0; snap = 1'b1;
    tick(); snap = 1'b0;
    check("post-rst no retained count", rd_data, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable, parametrised successor to the bench-side instruction/cache statistics counting in the processor hierarchy.
- Counts up to NUM_EVT single-bit event strobes (retired instruction, I/D cache request, I/D cache hit, ...) and elapsed cycles, gated by a run/halt state machine.
- Provides a snapshot shadow bank and a registered read port, so software or a bench can sample consistent counts without stopping the core.
- Sits beside proc, with strobes taken from the MEM/WB-stage and cache control outputs.

Parameters:
- NUM_EVT, 5, number of event channels; must be ≥1 and ≤ 2^SEL_W − 1.
- CNT_W, 32, width of every event counter and the cycle counter; must be ≥2.
- SEL_W, 3, width of rd_sel.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low: asserting rst=0 resets immediately; deassertion is sampled on clk.
- start  in  1  pulse: begin counting.
- halt  in  1  processor halt strobe.
- clear  in  1  synchronous zero of all counters, shadows and flags.
- snap  in  1  copy live counters into the shadow bank.
- evt  in  NUM_EVT  event strobes, bit i counts into counter i.
- rd_sel  in  SEL_W  read index: 0..NUM_EVT-1 selects an event; NUM_EVT selects the cycle counter.
- rd_data  out  CNT_W  registered shadow value at rd_sel.
- ovf  out  NUM_EVT+1  sticky saturation flags; bit NUM_EVT is the cycle counter.
- running  out  1  high in state RUN.
- done  out  1  high in state HALTED.

Behaviour:
- Reset (rst=0): state IDLE; all live counters, shadows, ovf, and rd_data are 0; running=0, done=0.

States:
- IDLE: no counting. start=1 → RUN.
- RUN: counting enabled. On each rising edge, the cycle counter increments by 1 and counter i increments when evt[i]=1. halt=1 → HALTED.
- HALTED: no counting. Only clear or reset leaves this state; start is ignored.

Halt cycle:
- The cycle in which halt=1 while in RUN is still counted, including its cycle tick and any evt bits.
- On that same edge, the shadow bank is loaded with the post-increment values (auto-snapshot).

Saturation:
- A counter at 2^CNT_W−1 holds its value and does not wrap.
- Its ovf bit sets on the edge where an increment is requested at all-ones.
- ovf bits are sticky until clear or reset.

clear:
- In any state, on the next edge: all live counters, shadows, and ovf are zeroed, and state → IDLE.
- Priority: clear > halt > start.
- clear together with snap: the shadows end up 0.

snap:
- In any state, shadow[k] ← live value after this edge's increment, for all k, atomically.
- snap and an auto-snapshot in the same edge are equivalent.

Read port:
- rd_data ← shadow[rd_sel] on each edge, giving 1-cycle latency.
- rd_sel > NUM_EVT returns 0.
- rd_data updates every cycle in every state, including the cycle after a snap, which already shows the new shadow.

Other rules:
- start while in RUN has no effect.
- evt bits are ignored outside RUN.
- Reset asserted mid-run clears everything asynchronously. No counts are retained.
- All arithmetic is unsigned, CNT_W bits. Each counter increments by at most 1 per cycle.

Test Plan:
1. Reset, then start; drive evt=5'b00001 for 10 cycles with other bits 0; snap; read sel 0 and sel 5 → rd_data=10 and 11 respectively (cycle count includes the snap cycle); ovf=0; running=1.
2. In RUN, halt=1 together with evt=5'b10000 → next cycle done=1, running=0. Shadow[4] includes that event. Further evt pulses do not change any count. start is ignored.
3. With CNT_W=4: run 20 cycles with evt[2]=1 → counter 2 holds 15 and ovf[2]=1. Then clear → all reads return 0, ovf=0, state IDLE.
4. Same edge with clear=1, halt=1, start=1 from RUN → state IDLE and all counters 0.
5. Mid-run assert rst=0 asynchronously, between clock edges → rd_data, ovf, running, and done drop to 0 immediately. After release, the state stays IDLE until start.
6. rd_sel=7 with NUM_EVT=5 → rd_data=0. Changing rd_sel from 0 to 5 → rd_data reflects the new index exactly one edge later.
